// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the memory-access / write-back stage: FSM states, datapath
// widths and the write-back bundle seen by the register file and forwarding.
package mem_wb_stage_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_W  = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic              en;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: enable is reloaded every cycle, index/data only
// change when a real write-back is loaded so bubbles keep the last value.
module mem_wb_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_d,
  input  logic [REG_W-1:0]  dest_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              wb_en,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en <= 1'b0;
      dest  <= '0;
      data  <= '0;
    end else begin
      wb_en <= wb_en_d;
      if (wb_en_d) begin
        dest <= dest_d;
        data <= data_d;
      end
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage + MEM/WB register. Loads/stores use a req/ready handshake
// and freeze upstream while outstanding. Optional abort timer: MEM_TIMEOUT_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W  = mem_wb_stage_pkg::DATA_W,
  parameter int ADDR_W  = mem_wb_stage_pkg::ADDR_W,
  parameter int REG_W   = mem_wb_stage_pkg::REG_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_wb_en,
  input  logic              ex_mem_r_en,
  input  logic              ex_mem_w_en,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_st_val,
  input  logic [REG_W-1:0]  ex_dest,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              writeBackEn,
  output logic [REG_W-1:0]  Dest_wb,
  output logic [DATA_W-1:0] Result_WB,
  output logic              mem_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic              is_mem;
  logic              abort;
  logic              wb_en_d;
  logic [DATA_W-1:0] wb_data_d;

  assign is_mem = ex_mem_r_en | ex_mem_w_en;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  // Abort fires on the TIMEOUT-th BUSY cycle; a same-cycle ready still wins.
  assign abort = (state == BUSY) && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = CNT_W'(TIMEOUT);
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    freeze    = 1'b0;
    wb_en_d   = 1'b0;
    wb_data_d = ex_alu_res;
    case (state)
      IDLE: begin
        freeze  = ex_valid & is_mem;
        wb_en_d = ex_valid & ~is_mem & ex_wb_en;
      end
      BUSY: begin
        freeze    = ~mem_ready & ~abort;
        wb_en_d   = mem_ready & ~mem_we & ex_wb_en;
        wb_data_d = mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
      mem_err   <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      mem_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ex_valid && is_mem) begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            mem_we    <= ex_mem_w_en;
            mem_addr  <= ADDR_W'(ex_alu_res);
            mem_wdata <= ex_st_val;
`ifdef MEM_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        BUSY: begin
          // Request fields stay put until completion; the next op can only
          // be accepted from IDLE, so requests never overlap.
          if (mem_ready || abort) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
`ifdef MEM_TIMEOUT_EN
          if (abort) mem_err <= 1'b1;
          else       cnt     <= cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_wb_reg (
    .clk     (clk),
    .rst     (rst),
    .wb_en_d (wb_en_d),
    .dest_d  (ex_dest),
    .data_d  (wb_data_d),
    .wb_en   (writeBackEn),
    .dest    (Dest_wb),
    .data    (Result_WB)
  );
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage and MEM/WB pipeline register of the ARM core.
- Takes EX-stage results and performs loads/stores over a request/ready handshake to data memory.
- Stalls the upstream pipeline (freeze) while a memory transaction is outstanding.
- Is the producer side of the register file write-back port: drives writeBackEn/Dest_wb/Result_WB on posedge, ahead of the register file's negedge write.

Parameters:
- DATA_W, 32, datapath and memory data width
- ADDR_W, 32, memory address width
- REG_W, 4, register index width (16 registers)
- TIMEOUT, 16, maximum BUSY cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_wb_en  in  1  instruction writes a register
- ex_mem_r_en  in  1  load
- ex_mem_w_en  in  1  store
- ex_alu_res  in  DATA_W  ALU result / memory address
- ex_st_val  in  DATA_W  store data
- ex_dest  in  REG_W  destination register
- freeze  out  1  upstream must hold ex_* stable and not advance
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  memory completes current request this cycle
- mem_rdata  in  DATA_W  load data, valid when mem_ready=1
- writeBackEn  out  1  register file write enable
- Dest_wb  out  REG_W  register file write index
- Result_WB  out  DATA_W  register file write data
- mem_err  out  1  one-cycle abort pulse; tied 0 without MEM_TIMEOUT_EN

Behaviour:
- Reset (synchronous, active-high): state=IDLE; mem_req, mem_we, writeBackEn, mem_err=0; mem_addr, mem_wdata, Dest_wb, Result_WB=0. Reset mid-transaction drops mem_req at that edge, with no write-back and no error pulse.
- is_mem = ex_mem_r_en | ex_mem_w_en. If both are set, the instruction is a store (w_en wins).
- FSM states: IDLE, BUSY.
- IDLE with ex_valid & is_mem:
  - freeze=1 combinationally.
  - At the edge: state->BUSY; mem_req=1; mem_we=ex_mem_w_en; mem_addr=ex_alu_res; mem_wdata=ex_st_val; writeBackEn loads 0.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - freeze = ~mem_ready.
  - On mem_ready=1: at the edge state->IDLE and mem_req=0.
    - Load: writeBackEn=ex_wb_en, Dest_wb=ex_dest, Result_WB=mem_rdata.
    - Store: writeBackEn=0.
- IDLE with ex_valid & ~is_mem: freeze=0; at the edge writeBackEn=ex_wb_en, Dest_wb=ex_dest, Result_WB=ex_alu_res. Latency is 1 cycle.
- IDLE with ex_valid=0: writeBackEn loads 0 (bubble).
- Dest_wb/Result_WB load only when writeBackEn loads 1; otherwise they hold their previous value.
- mem_ready while IDLE is ignored.
- Load timing: instruction presented in cycle N; mem_req high in N+1; earliest mem_ready in N+1; write-back visible in N+2. Each extra wait cycle adds one.
- Store with ex_wb_en=1 never writes back.
- Back-to-back memory ops: the next op is accepted in the cycle after completion. No request overlap; a new request is never issued on the completion edge.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - A BUSY cycle counter (width clog2(TIMEOUT+1)) clears on entry to BUSY.
  - If TIMEOUT cycles elapse with mem_ready=0: at that edge state->IDLE, mem_req=0, writeBackEn=0, and mem_err=1 for one cycle.
  - freeze is 0 in the abort cycle, so the instruction retires without effect.
  - mem_ready in the abort cycle wins: normal completion, no error.
- Without the macro: no counter, mem_err constant 0, BUSY waits indefinitely.

Decomposition:
- Shared package: FSM state enum (IDLE, BUSY), DATA_W/ADDR_W/REG_W constants, and a write-back bundle typedef (en, dest, data) reused by the register file and forwarding logic.
- One sub-module: mem_wb_reg, the MEM/WB pipeline register (load-enable, hold-on-bubble, synchronous reset).

Test Plan:
- ALU op: ex_valid=1, ex_wb_en=1, ex_dest=3, ex_alu_res=0x1234, no mem -> next cycle writeBackEn=1, Dest_wb=3, Result_WB=0x1234, freeze never asserted.
- Load, ready after 2 wait cycles: ex_alu_res=0x40, ex_dest=5, mem_rdata=0xCAFEF00D -> mem_req high 3 cycles with mem_addr=0x40, mem_we=0; freeze high 3 cycles; then writeBackEn=1, Dest_wb=5, Result_WB=0xCAFEF00D; regfile r5 reads 0xCAFEF00D after the next negedge.
- Store with ex_wb_en=1, ex_st_val=0xA5A5A5A5, ex_alu_res=0x80, ready in first req cycle -> one req cycle with mem_we=1, mem_wdata=0xA5A5A5A5; writeBackEn stays 0; Dest_wb/Result_WB unchanged.
- Reset asserted during BUSY -> mem_req=0 and writeBackEn=0 after that edge, state IDLE; a stray mem_ready the next cycle causes no write-back.
- Back-to-back load then ALU op -> load write-back, then ALU write-back exactly one cycle later; no gap or duplicate writeBackEn.
- MEM_TIMEOUT_EN, TIMEOUT=16, mem_ready held 0 -> mem_req drops after 16 cycles, mem_err pulses one cycle, freeze released, no write-back.
